fetch_ifid: RTL
===============

FETCH_IFID -- requirements
Module: fetch_ifid

Interface
REQ-001 SHALL provide parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 SHALL provide parameter NOP_INSTR, default 16'b00001_00000000000, bubble word driven into IF/ID.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 stall  input  1  hold IF/ID and PC (hazard unit).
REQ-006 redirect  input  1  taken branch/jump from a later stage; flush fetch.
REQ-007 redirect_pc  input  16  target PC, valid with redirect.
REQ-008 imem_rdata  input  16  instruction word, valid when imem_done=1.
REQ-009 imem_done  input  1  memory access complete, same cycle as imem_rd or later.
REQ-010 imem_rd  output  1  fetch request; held high with stable imem_addr until imem_done.
REQ-011 imem_addr  output  16  fetch address.
REQ-012 instr_out  output  16  IF/ID instruction to decode.
REQ-013 nextPC_out  output  16  IF/ID PC+2 of instr_out.
REQ-014 valid_out  output  1  instr_out is a real fetched instruction.
REQ-015 halted  output  1  fetch stopped after HALT.

Function
REQ-016 SHALL implement FSM states FETCH, WAIT, DRAIN, HALT; reset state FETCH.
REQ-017 FETCH: imem_rd=1, imem_addr=pc when skid buffer empty; imem_rd=0 when buffer full; imem_done=1 -> stay FETCH; imem_rd=1 and no done -> WAIT.
REQ-018 WAIT: imem_rd=1, imem_addr=pc; imem_done -> FETCH.
REQ-019 DRAIN: imem_rd=1, imem_addr=drain_addr (PC latched at redirect); imem_done -> FETCH, data discarded.
REQ-020 HALT: imem_rd=0; halted=1; IF/ID loads NOP_INSTR, valid_out=0 each unstalled cycle.
REQ-021 Word accepted when imem_done=1 in FETCH/WAIT with no redirect: PC <= PC+2, modulo 2^16 (16'hFFFE -> 16'h0000).
REQ-022 Unstalled cycle: IF/ID loads buffer entry if full (buffer cleared), else accepted word with nextPC=PC+2 and valid_out=1, else NOP_INSTR, valid_out=0, nextPC_out unchanged.
REQ-023 Stall with word accepted: word and PC+2 written to one-entry skid buffer; IF/ID holds.
REQ-024 Stall, no word: IF/ID, PC, buffer hold; FSM still advances on imem_done.
REQ-025 Redirect has priority over stall: IF/ID <= NOP_INSTR/valid 0, PC <= redirect_pc, buffer cleared, any same-cycle word discarded.
REQ-026 Redirect in WAIT without imem_done -> DRAIN, drain_addr <= old PC; redirect in DRAIN updates PC only, stays DRAIN.
REQ-027 Redirect in HALT -> FETCH, halted=0 next cycle.
REQ-028 Word with opcode [15:11]=5'b00000 loaded into IF/ID (valid_out=1) -> HALT next cycle; no further requests.
REQ-029 Fetch latency: imem_done at cycle N, unstalled -> instr_out valid at cycle N+1.

Reset
REQ-030 rst=1 SHALL immediately force: PC=RESET_PC, state FETCH, buffer empty, instr_out=NOP_INSTR, nextPC_out=16'h0000, valid_out=0, halted=0.
REQ-031 While rst=1, imem_rd=0; first request at imem_addr=RESET_PC the cycle after rst falls.
REQ-032 rst asserted mid-WAIT/DRAIN SHALL abandon the access; late imem_done for it is the memory's responsibility to suppress.

Verification
REQ-033 Reset, imem_done=1 every cycle, words 16'h4001,16'h4002 -> instr_out 16'h4001/nextPC 16'h0002 then 16'h4002/16'h0004, valid_out=1.
REQ-034 imem_done 3 cycles late -> imem_rd/imem_addr stable 4 cycles, valid_out=0 bubbles, then word with correct nextPC.
REQ-035 stall high 2 cycles while word 16'h4003 returns -> IF/ID holds, imem_rd=0 during buffer-full, 16'h4003 appears first cycle after stall drops.
REQ-036 redirect to 16'h0100 during WAIT -> DRAIN on old address, returned word discarded, next request at 16'h0100, IF/ID NOP.
REQ-037 Fetch 16'h0000 (HALT) -> halted=1, imem_rd=0; later redirect to 16'h0020 -> fetch resumes at 16'h0020.
REQ-038 PC 16'hFFFE fetched -> nextPC_out=16'h0000, next imem_addr=16'h0000.

Source files
------------

// File: rtl/fetch_ifid_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_rd    : fetch request, held with a stable imem_addr until imem_done
//   imem_addr  : 16-bit fetch address
//   imem_rdata : 16-bit instruction word, valid while imem_done=1
//   imem_done  : access complete (same cycle as imem_rd or later)
// master = fetch stage, slave = instruction memory.
interface fetch_ifid_if;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_done;

  modport master (
    output imem_rd,
    output imem_addr,
    input  imem_rdata,
    input  imem_done
  );

  modport slave (
    input  imem_rd,
    input  imem_addr,
    output imem_rdata,
    output imem_done
  );
endinterface

// File: rtl/fetch_ifid.sv
// Fetch stage with IF/ID pipeline register and a one-entry skid buffer.
// Issues requests on the instruction-memory bus, absorbs one returned word
// while decode is stalled, flushes on redirect (draining any in-flight access
// whose data must be thrown away) and stops fetching after a HALT opcode.
// Ports:
//   clk, rst      : single rising-edge clock, asynchronous active-high reset
//   stall         : hold IF/ID and PC (hazard unit)
//   redirect      : taken branch/jump from a later stage, redirect_pc = target
//   imem          : instruction-memory bus (master side)
//   instr_out     : IF/ID instruction
//   nextPC_out    : IF/ID PC+2 of instr_out
//   valid_out     : instr_out is a real fetched instruction
//   halted        : fetch stopped after HALT
module fetch_ifid #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'b00001_00000000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         redirect,
  input  logic [15:0]  redirect_pc,
  fetch_ifid_if.master imem,
  output logic [15:0]  instr_out,
  output logic [15:0]  nextPC_out,
  output logic         valid_out,
  output logic         halted
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] drain_addr_q, drain_addr_d;
  logic        buf_valid_q, buf_valid_d;
  logic [15:0] buf_instr_q, buf_instr_d;
  logic [15:0] buf_npc_q, buf_npc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] nextpc_q, nextpc_d;
  logic        valid_q, valid_d;

  logic        req;
  logic [15:0] req_addr;
  logic        accept;
  logic [15:0] pc_plus2;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    buf_valid_d  = buf_valid_q;
    buf_instr_d  = buf_instr_q;
    buf_npc_d    = buf_npc_q;
    instr_d      = instr_q;
    nextpc_d     = nextpc_q;
    valid_d      = valid_q;
    req          = 1'b0;
    req_addr     = pc_q;
    pc_plus2     = pc_q + 16'd2;

    // Request generation: FETCH only asks when the skid buffer has room.
    unique case (state_q)
      ST_FETCH: req = !buf_valid_q;
      ST_WAIT:  req = 1'b1;
      ST_DRAIN: begin
        req      = 1'b1;
        req_addr = drain_addr_q;
      end
      ST_HALT:  req = 1'b0;
      default:  req = 1'b0;
    endcase

    // A returned word is kept only for a live (non-drain) access and only if
    // no redirect arrives in the same cycle.
    accept = req && imem.imem_done && (state_q != ST_DRAIN) && !redirect;

    // Next state. An access already on the bus must run to completion with a
    // stable address, so a redirect that lands while one is pending (FETCH
    // that just issued, or WAIT) parks in DRAIN on the old address.
    unique case (state_q)
      ST_FETCH, ST_WAIT: begin
        if (req) begin
          if (imem.imem_done) begin
            state_d = ST_FETCH;
          end else if (redirect) begin
            state_d      = ST_DRAIN;
            drain_addr_d = pc_q;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_DRAIN: if (imem.imem_done) state_d = ST_FETCH;
      ST_HALT:  if (redirect) state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase

    // PC: redirect wins, otherwise advance by one word per accepted fetch.
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (accept) begin
      pc_d = pc_plus2;
    end

    // IF/ID and skid buffer.
    if (redirect) begin
      instr_d     = NOP_INSTR;
      valid_d     = 1'b0;
      buf_valid_d = 1'b0;
    end else if (!stall) begin
      if (buf_valid_q) begin
        instr_d     = buf_instr_q;
        nextpc_d    = buf_npc_q;
        valid_d     = 1'b1;
        buf_valid_d = 1'b0;
      end else if (accept) begin
        instr_d  = imem.imem_rdata;
        nextpc_d = pc_plus2;
        valid_d  = 1'b1;
      end else begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      // A real HALT word entering decode stops fetching from the next cycle.
      if (valid_d && (instr_d[15:11] == 5'b00000)) begin
        state_d = ST_HALT;
      end
    end else if (accept) begin
      buf_valid_d = 1'b1;
      buf_instr_d = imem.imem_rdata;
      buf_npc_d   = pc_plus2;
    end
  end

  // NOTE: non-blocking assignments in clocked blocks so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      buf_valid_q  <= 1'b0;
      instr_q      <= NOP_INSTR;
      nextpc_q     <= 16'h0000;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      buf_valid_q  <= buf_valid_d;
      instr_q      <= instr_d;
      nextpc_q     <= nextpc_d;
      valid_q      <= valid_d;
    end
  end

  // NOTE: the skid payload is not reset; buf_valid_q alone says whether it
  // holds anything, so its contents after reset are never observed.
  always_ff @(posedge clk) begin
    buf_instr_q <= buf_instr_d;
    buf_npc_q   <= buf_npc_d;
  end

  // No request may leave the block while reset is held.
  assign imem.imem_rd   = req && !rst;
  assign imem.imem_addr = req_addr;

  assign instr_out  = instr_q;
  assign nextPC_out = nextpc_q;
  assign valid_out  = valid_q;
  assign halted     = (state_q == ST_HALT);

endmodule
